// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared types and sizing constants for the reorder buffer
package rob_pkg;

    localparam int ROB_DEPTH     = 16;
    localparam int TAG_W         = $clog2(ROB_DEPTH);
    localparam int COMMIT_WIDTH  = 2;
    localparam int REG_VAL_WIDTH = 32;
    localparam int ARCH_REG_W    = 5;

    typedef enum logic {
        reg_commit   = 1'b0,
        store_commit = 1'b1
    } commit_type_e;

    typedef struct packed {
        logic                     valid;
        logic                     done;
        commit_type_e             ctype;
        logic [ARCH_REG_W-1:0]    arch_reg;
        logic [REG_VAL_WIDTH-1:0] value;
    } rob_entry_t;

endpackage

// File: rtl/rob_commit_select.sv
// rtl/rob_commit_select.sv - in-order retire selection over the head window
// Slots retire oldest-first; the first non-retirable slot closes the window, one store per cycle.
module rob_commit_select
    import rob_pkg::*;
#(
    parameter int COMMIT_WIDTH = rob_pkg::COMMIT_WIDTH,
    parameter int NC_W         = $clog2(COMMIT_WIDTH + 1)
) (
    input  logic                    enable_i,
    input  logic [COMMIT_WIDTH-1:0] win_valid_i,
    input  logic [COMMIT_WIDTH-1:0] win_done_i,
    input  commit_type_e            win_type_i [COMMIT_WIDTH],
    input  logic                    store_ready_i,
    output logic [COMMIT_WIDTH-1:0] sel_mask_o,
    output logic [NC_W-1:0]         ncommit_o
);

    logic open_v;
    logic store_taken_v;

    always_comb begin
        sel_mask_o    = '0;
        ncommit_o     = '0;
        open_v        = enable_i;
        store_taken_v = 1'b0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (open_v && win_valid_i[i] && win_done_i[i] &&
                ((win_type_i[i] == reg_commit) || (store_ready_i && !store_taken_v))) begin
                sel_mask_o[i] = 1'b1;
                ncommit_o     = ncommit_o + NC_W'(1);
                if (win_type_i[i] == store_commit) begin
                    store_taken_v = 1'b1;
                end
            end else begin
                open_v = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_commit_unit.sv
// rtl/rob_commit_unit.sv - in-order reorder buffer with registered multi-slot commit
// Optional ROB_COMMIT_STATS_EN adds saturating retire / full-stall counters.
module rob_commit_unit
    import rob_pkg::*;
#(
    parameter int ROB_DEPTH     = rob_pkg::ROB_DEPTH,
    parameter int COMMIT_WIDTH  = rob_pkg::COMMIT_WIDTH,
    parameter int REG_VAL_WIDTH = rob_pkg::REG_VAL_WIDTH,
    parameter int ARCH_REG_W    = rob_pkg::ARCH_REG_W,
    parameter int TAG_W         = $clog2(ROB_DEPTH)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                alloc_valid,
    output logic                                alloc_ready,
    input  logic                                alloc_type,
    input  logic [ARCH_REG_W-1:0]               alloc_arch_reg,
    output logic [TAG_W-1:0]                    alloc_tag,
    input  logic                                complete_valid,
    input  logic [TAG_W-1:0]                    complete_tag,
    input  logic [REG_VAL_WIDTH-1:0]            complete_value,
    input  logic                                store_commit_ready,
    input  logic                                flush,
    output logic [COMMIT_WIDTH-1:0]             commit_valid,
    output logic [COMMIT_WIDTH-1:0]             commit_type,
    output logic [COMMIT_WIDTH*ARCH_REG_W-1:0]  commit_arch_reg_addr,
    output logic [COMMIT_WIDTH*REG_VAL_WIDTH-1:0] commit_value,
    output logic                                rob_empty
`ifdef ROB_COMMIT_STATS_EN
    ,
    output logic [31:0]                         stat_commits,
    output logic [31:0]                         stat_full_cycles
`endif
);

    localparam int COUNT_W = TAG_W + 1;
    localparam int NC_W    = $clog2(COMMIT_WIDTH + 1);

    rob_entry_t                          entries_q [ROB_DEPTH];
    logic [TAG_W-1:0]                    head_q, head_d;
    logic [TAG_W-1:0]                    tail_q, tail_d;
    logic [COUNT_W-1:0]                  count_q, count_d;
    logic                                empty_q;
    logic [COMMIT_WIDTH-1:0]             commit_valid_q;
    logic [COMMIT_WIDTH-1:0]             commit_type_q;
    logic [COMMIT_WIDTH*ARCH_REG_W-1:0]  commit_addr_q;
    logic [COMMIT_WIDTH*REG_VAL_WIDTH-1:0] commit_value_q;

    logic [TAG_W-1:0]                    win_idx [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0]             win_valid;
    logic [COMMIT_WIDTH-1:0]             win_done;
    commit_type_e                        win_type [COMMIT_WIDTH];
    logic [COMMIT_WIDTH-1:0]             sel_mask;
    logic [NC_W-1:0]                     ncommit;
    logic                                alloc_fire;

    // Space is judged from the registered count only; retiring entries free slots next cycle.
    assign alloc_ready = (count_q != COUNT_W'(ROB_DEPTH));
    assign alloc_fire  = alloc_valid && alloc_ready && !flush;
    assign alloc_tag   = tail_q;

    always_comb begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            win_idx[i]   = head_q + TAG_W'(i);
            win_valid[i] = entries_q[win_idx[i]].valid;
            win_done[i]  = entries_q[win_idx[i]].done;
            win_type[i]  = entries_q[win_idx[i]].ctype;
        end
    end

    rob_commit_select #(
        .COMMIT_WIDTH (COMMIT_WIDTH),
        .NC_W         (NC_W)
    ) u_select (
        .enable_i      (!flush),
        .win_valid_i   (win_valid),
        .win_done_i    (win_done),
        .win_type_i    (win_type),
        .store_ready_i (store_commit_ready),
        .sel_mask_o    (sel_mask),
        .ncommit_o     (ncommit)
    );

    always_comb begin
        head_d  = head_q + TAG_W'(ncommit);
        tail_d  = tail_q + TAG_W'(alloc_fire);
        count_d = count_q + COUNT_W'(alloc_fire) - COUNT_W'(ncommit);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries_q[i].valid <= 1'b0;
                entries_q[i].done  <= 1'b0;
            end
        end else begin
            if (complete_valid && entries_q[complete_tag].valid) begin
                entries_q[complete_tag].done  <= 1'b1;
                entries_q[complete_tag].value <= complete_value;
            end
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (sel_mask[i]) begin
                    entries_q[win_idx[i]].valid <= 1'b0;
                    entries_q[win_idx[i]].done  <= 1'b0;
                end
            end
            // The tail slot is never in the retire window while alloc_ready is high.
            if (alloc_fire) begin
                entries_q[tail_q].valid    <= 1'b1;
                entries_q[tail_q].done     <= 1'b0;
                entries_q[tail_q].ctype    <= commit_type_e'(alloc_type);
                entries_q[tail_q].arch_reg <= alloc_arch_reg;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            empty_q        <= 1'b1;
            commit_valid_q <= '0;
            commit_type_q  <= '0;
            commit_addr_q  <= '0;
            commit_value_q <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            empty_q        <= (count_d == '0);
            commit_valid_q <= sel_mask;
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (sel_mask[i]) begin
                    commit_type_q[i] <= entries_q[win_idx[i]].ctype;
                    commit_addr_q[i*ARCH_REG_W +: ARCH_REG_W] <= entries_q[win_idx[i]].arch_reg;
                    commit_value_q[i*REG_VAL_WIDTH +: REG_VAL_WIDTH] <= entries_q[win_idx[i]].value;
                end
            end
        end
    end

    assign commit_valid         = commit_valid_q;
    assign commit_type          = commit_type_q;
    assign commit_arch_reg_addr = commit_addr_q;
    assign commit_value         = commit_value_q;
    assign rob_empty            = empty_q;

`ifdef ROB_COMMIT_STATS_EN
    logic [31:0] stat_commits_q;
    logic [31:0] stat_full_q;
    logic [32:0] commit_sum;

    assign commit_sum = {1'b0, stat_commits_q} + 33'(ncommit);

    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_commits_q <= '0;
            stat_full_q    <= '0;
        end else begin
            stat_commits_q <= commit_sum[32] ? '1 : commit_sum[31:0];
            if (!alloc_ready && alloc_valid && (stat_full_q != '1)) begin
                stat_full_q <= stat_full_q + 32'd1;
            end
        end
    end

    assign stat_commits     = stat_commits_q;
    assign stat_full_cycles = stat_full_q;
`endif

endmodule

// File: tb/tb_rob_commit_unit.sv
// tb/tb_rob_commit_unit.sv - scoreboard bench for rob_commit_unit
module tb_rob_commit_unit;

    logic        clk;
    logic        reset;
    logic        alloc_valid;
    logic        alloc_ready;
    logic        alloc_type;
    logic [4:0]  alloc_arch_reg;
    logic [3:0]  alloc_tag;
    logic        complete_valid;
    logic [3:0]  complete_tag;
    logic [31:0] complete_value;
    logic        store_commit_ready;
    logic        flush;
    logic [1:0]  commit_valid;
    logic [1:0]  commit_type;
    logic [9:0]  commit_arch_reg_addr;
    logic [63:0] commit_value;
    logic        rob_empty;

    rob_commit_unit dut (
        .clk                  (clk),
        .reset                (reset),
        .alloc_valid          (alloc_valid),
        .alloc_ready          (alloc_ready),
        .alloc_type           (alloc_type),
        .alloc_arch_reg       (alloc_arch_reg),
        .alloc_tag            (alloc_tag),
        .complete_valid       (complete_valid),
        .complete_tag         (complete_tag),
        .complete_value       (complete_value),
        .store_commit_ready   (store_commit_ready),
        .flush                (flush),
        .commit_valid         (commit_valid),
        .commit_type          (commit_type),
        .commit_arch_reg_addr (commit_arch_reg_addr),
        .commit_value         (commit_value),
        .rob_empty            (rob_empty)
    );

    typedef struct {
        logic       typ;
        logic [4:0] addr;
        logic [3:0] tag;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] val_m [16];
    logic [3:0]  exp_tail;
    int          n_checks;
    int          n_fails;
    int          commits_seen;
    int          dual_cycles;
    int          max_stores;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard consumer: every strobed slot must match the oldest outstanding allocation.
    always @(negedge clk) begin
        int   nst;
        exp_t e;
        nst = 0;
        for (int i = 0; i < 2; i++) begin
            if (commit_valid[i]) begin
                commits_seen++;
                if (commit_type[i]) nst++;
                check_eq("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("commit_type", 64'(commit_type[i]), 64'(e.typ));
                    check_eq("commit_addr", 64'(commit_arch_reg_addr[i*5 +: 5]), 64'(e.addr));
                    check_eq("commit_value", 64'(commit_value[i*32 +: 32]), 64'(val_m[e.tag]));
                end
            end
        end
        if (commit_valid == 2'b11) dual_cycles++;
        if (nst > max_stores) max_stores = nst;
    end

    task automatic do_alloc(input logic typ, input logic [4:0] addr);
        exp_t e;
        check_eq("alloc_ready_pre", 64'(alloc_ready), 64'd1);
        check_eq("alloc_tag", 64'(alloc_tag), 64'(exp_tail));
        e.typ = typ; e.addr = addr; e.tag = exp_tail;
        exp_q.push_back(e);
        exp_tail = exp_tail + 4'd1;
        alloc_valid = 1'b1; alloc_type = typ; alloc_arch_reg = addr;
        @(posedge clk); #1;
        alloc_valid = 1'b0;
    endtask

    task automatic do_complete(input logic [3:0] tg, input logic [31:0] v, input logic take);
        if (take) val_m[tg] = v;
        complete_valid = 1'b1; complete_tag = tg; complete_value = v;
        @(posedge clk); #1;
        complete_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        exp_q.delete();
        exp_tail = '0;
    endtask

    task automatic wait_empty(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (rob_empty) break;
        end
        @(negedge clk); #1;
        check_eq("drain_empty", 64'(rob_empty), 64'd1);
        check_eq("drain_sb", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int c0, d0;
        logic [3:0] t2;
        n_checks = 0; n_fails = 0; commits_seen = 0; dual_cycles = 0; max_stores = 0;
        exp_tail = '0;
        reset = 1'b0; alloc_valid = 1'b0; alloc_type = 1'b0; alloc_arch_reg = '0;
        complete_valid = 1'b0; complete_tag = '0; complete_value = '0;
        store_commit_ready = 1'b1; flush = 1'b0;
        for (int i = 0; i < 16; i++) val_m[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_commit_valid", 64'(commit_valid), 64'd0);
        check_eq("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        check_eq("rst_rob_empty", 64'(rob_empty), 64'd1);
        check_eq("rst_alloc_tag", 64'(alloc_tag), 64'd0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check_eq("idle_commit_valid", 64'(commit_valid), 64'd0);
        end

        // Two regs completed youngest-first retire together.
        do_alloc(1'b0, 5'd1);
        do_alloc(1'b0, 5'd2);
        do_complete(4'd1, 32'hBB, 1'b1);
        do_complete(4'd0, 32'hAA, 1'b1);
        check_eq("commit_latency", 64'(commit_valid), 64'd0);
        @(posedge clk); #1;
        check_eq("dual_commit", 64'(commit_valid), 64'd3);
        check_eq("dual_val0", 64'(commit_value[31:0]), 64'hAA);
        check_eq("dual_val1", 64'(commit_value[63:32]), 64'hBB);
        wait_empty(10);

        // Fill to full, free two, tail wraps.
        do_flush();
        check_eq("flush0_empty", 64'(rob_empty), 64'd1);
        for (int i = 0; i < 16; i++) do_alloc(1'b0, 5'(i + 8));
        check_eq("full_alloc_ready", 64'(alloc_ready), 64'd0);
        check_eq("full_tail_wrap", 64'(alloc_tag), 64'd0);
        do_complete(4'd1, 32'h1111, 1'b1);
        do_complete(4'd0, 32'h1000, 1'b1);
        check_eq("full_ready_hold", 64'(alloc_ready), 64'd0);
        @(posedge clk); #1;
        check_eq("full_dual", 64'(commit_valid), 64'd3);
        check_eq("full_ready_free", 64'(alloc_ready), 64'd1);
        do_alloc(1'b0, 5'd30);
        for (int t = 2; t < 16; t++) do_complete(4'(t), $urandom, 1'b1);
        do_complete(4'd0, $urandom, 1'b1);
        wait_empty(30);

        // Stores retire one per cycle.
        c0 = commits_seen; d0 = dual_cycles;
        t2 = exp_tail;
        do_alloc(1'b1, 5'd3);
        do_alloc(1'b1, 5'd4);
        do_complete(t2 + 4'd1, 32'h5151, 1'b1);
        do_complete(t2, 32'h5050, 1'b1);
        wait_empty(10);
        check_eq("store_commits", 64'(commits_seen - c0), 64'd2);
        check_eq("store_no_dual", 64'(dual_cycles - d0), 64'd0);
        check_eq("store_max_per_cycle", 64'(max_stores), 64'd1);

        // Blocked store holds back a younger done reg.
        store_commit_ready = 1'b0;
        c0 = commits_seen; d0 = dual_cycles;
        t2 = exp_tail;
        do_alloc(1'b1, 5'd5);
        do_alloc(1'b0, 5'd6);
        do_complete(t2 + 4'd1, 32'h6666, 1'b1);
        do_complete(t2, 32'h5555, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check_eq("blocked_commits", 64'(commits_seen - c0), 64'd0);
        check_eq("blocked_not_empty", 64'(rob_empty), 64'd0);
        store_commit_ready = 1'b1;
        wait_empty(10);
        check_eq("unblock_commits", 64'(commits_seen - c0), 64'd2);
        check_eq("unblock_dual", 64'(dual_cycles - d0), 64'd1);

        // Flush with pending work, then stale completion is ignored.
        t2 = exp_tail;
        for (int i = 0; i < 5; i++) do_alloc(1'b0, 5'(i + 16));
        do_complete(t2 + 4'd1, 32'h7777, 1'b1);
        c0 = commits_seen;
        do_flush();
        check_eq("flush_commit_valid", 64'(commit_valid), 64'd0);
        check_eq("flush_rob_empty", 64'(rob_empty), 64'd1);
        check_eq("flush_alloc_tag", 64'(alloc_tag), 64'd0);
        do_complete(4'd3, 32'h3333, 1'b0);
        for (int i = 0; i < 4; i++) do_alloc(1'b0, 5'(i + 24));
        for (int t = 0; t < 3; t++) do_complete(4'(t), 32'h900 + 32'(t), 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check_eq("stale_not_empty", 64'(rob_empty), 64'd0);
        check_eq("stale_sb_left", 64'(exp_q.size()), 64'd1);
        check_eq("flush_commits", 64'(commits_seen - c0), 64'd3);
        do_complete(4'd3, 32'h903, 1'b1);
        wait_empty(10);

        // Asynchronous reset while a dual commit is on the outputs.
        t2 = exp_tail;
        do_alloc(1'b0, 5'd11);
        do_alloc(1'b0, 5'd12);
        do_complete(t2 + 4'd1, 32'hC1, 1'b1);
        do_complete(t2, 32'hC0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (commit_valid == 2'b11) break;
        end
        check_eq("pre_async_dual", 64'(commit_valid), 64'd3);
        #1 reset = 1'b0;
        #1;
        check_eq("async_commit_valid", 64'(commit_valid), 64'd0);
        check_eq("async_commit_value", 64'(commit_value), 64'd0);
        check_eq("async_rob_empty", 64'(rob_empty), 64'd1);
        check_eq("async_alloc_ready", 64'(alloc_ready), 64'd1);
        exp_q.delete();
        exp_tail = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        do_alloc(1'b0, 5'd7);
        do_complete(4'd0, 32'hDEAD, 1'b1);
        wait_empty(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- In-order reorder buffer and commit stage. It sits directly upstream of the architectural register file wrapper and drives its COMMIT_IF signals.
- Rename/dispatch allocates entries in program order. Execution writeback marks entries done out of order.
- Up to COMMIT_WIDTH oldest done entries retire per cycle. Retiring entries go to the arch regfile (reg_commit) or the store path (store_commit).

Parameters:
- ROB_DEPTH, 16, number of entries; power of two, >= 4.
- COMMIT_WIDTH, 2, max commits per cycle; equals `MAX_NUM_OF_COMMITS.
- REG_VAL_WIDTH, 32, result width; equals `REG_VAL_WIDTH.
- ARCH_REG_W, 5, architectural register address width.
- TAG_W, $clog2(ROB_DEPTH), ROB tag width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- alloc_valid  in  1  dispatch requests one entry.
- alloc_ready  out  1  ROB can accept an allocation this cycle.
- alloc_type  in  1  0 = reg_commit, 1 = store_commit.
- alloc_arch_reg  in  ARCH_REG_W  destination architectural register.
- alloc_tag  out  TAG_W  tag assigned to the allocation (current tail).
- complete_valid  in  1  writeback result valid.
- complete_tag  in  TAG_W  entry being completed.
- complete_value  in  REG_VAL_WIDTH  result value.
- store_commit_ready  in  1  store path can retire a store this cycle.
- flush  in  1  discard all entries.
- commit_valid  out  COMMIT_WIDTH  per-slot commit strobe.
- commit_type  out  COMMIT_WIDTH  per-slot type (reg_commit / store_commit).
- commit_arch_reg_addr  out  COMMIT_WIDTH*ARCH_REG_W  per-slot destination.
- commit_value  out  COMMIT_WIDTH*REG_VAL_WIDTH  per-slot value.
- rob_empty  out  1  count == 0.

Behaviour:
- Reset (reset low, asynchronous):
  - head = tail = 0, count = 0, all valid/done bits cleared.
  - All commit_* outputs 0, alloc_ready = 1, rob_empty = 1.
- Allocation:
  - alloc_ready = (count != ROB_DEPTH), from registered count only; same-cycle commits do not free space.
  - Fire = alloc_valid & alloc_ready. On fire, write {type, arch_reg, valid = 1, done = 0} at tail; tail += 1 modulo ROB_DEPTH.
- Completion:
  - If complete_valid and entry[complete_tag].valid: set done and store the value at the clock edge.
  - Completion to an invalid entry is ignored.
- Commit selection (combinational from registered state):
  - Slot i (0..COMMIT_WIDTH-1) is selected if entry head+i is valid & done and all slots j < i are selected.
  - A store_commit entry additionally needs store_commit_ready, and at most one store retires per cycle. A blocked store stops all younger slots.
- Commit outputs are registered. A completion sampled at edge E can appear on commit_valid after edge E+1, not earlier.
- Head and count update:
  - head += number of selected slots.
  - count += alloc_fire - ncommit, all in the same cycle.
  - Pointers wrap modulo ROB_DEPTH, with count distinguishing full from empty.
- Flush (synchronous, highest priority):
  - Clears all valid/done bits and sets head = tail = count = 0.
  - In the flush cycle, alloc and completion are ignored and no commits are selected, so commit_valid is 0 on the next cycle.
- Unused commit slots drive commit_valid = 0. Their address and value fields hold their previous contents.
- rob_empty is registered alongside count.

Optional Feature:
- ROB_COMMIT_STATS_EN defined: adds outputs stat_commits (32 bit, total retired entries) and stat_full_cycles (32 bit, cycles with count == ROB_DEPTH and alloc_valid high).
  - Both saturate at all-ones.
  - Both reset to 0 on reset low; flush does not clear them.
- Undefined: the counters and ports do not exist; all other behaviour is identical.

Decomposition:
- Shared package (rob_pkg): commit_type_e {reg_commit, store_commit}, rob_entry_t {valid, done, type, arch_reg, value}, and the ROB_DEPTH / TAG_W constants.
- One natural sub-module, rob_commit_select: combinational priority logic producing the selected-slot mask and ncommit from the head window.

Test Plan:
- Reset then idle: commit_valid = 0, alloc_ready = 1, rob_empty = 1; no commits for 10 cycles.
- Alloc x1 (reg_commit) then x2 (reg_commit); complete tag1 = 0xBB, then tag0 = 0xAA.
  - Expect a single cycle with commit_valid = 2'b11, value slot0 = 0xAA, slot1 = 0xBB, addr slot0 = 1, slot1 = 2.
- Fill 16 entries: alloc_ready = 0 on the cycle after the 16th allocation.
  - Commit 2 entries; alloc_ready = 1 one cycle later.
  - Tail wraps to 0 and the next alloc_tag = 0.
- Two store_commit entries, both done, store_commit_ready = 1: they retire on consecutive cycles, one per cycle.
  - With store_commit_ready = 0 held, the store head blocks a done reg_commit behind it.
- Flush with 5 entries pending, one of them done:
  - commit_valid = 0 next cycle; rob_empty = 1.
  - A subsequent complete_tag = 3 is ignored.
  - The next alloc_tag = 0.
- Assert reset mid-run with commit_valid = 2'b11: outputs clear immediately (asynchronously), with no dependence on a clock edge.
